// File: rtl/rr_burst_arbiter_if.sv
// Requester/resource bundle for the round-robin burst arbiter.
// The slave modport is the arbiter's view; master is the surrounding fabric's view.
interface rr_burst_arbiter_if #(
    parameter int unsigned N  = 4,
    parameter int unsigned DW = 8
);
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_last;
    logic [N*DW-1:0] req_data;
    logic [N-1:0]    req_ready;

    logic            res_valid;
    logic            res_last;
    logic [DW-1:0]   res_data;
    logic            res_ready;

    logic [N-1:0]    grant;
    logic [IW-1:0]   res_sel;
    logic            busy;
    logic            timeout;

    modport slave (
        input  req_valid, req_last, req_data, res_ready,
        output req_ready, res_valid, res_last, res_data,
        output grant, res_sel, busy, timeout
    );

    modport master (
        output req_valid, req_last, req_data, res_ready,
        input  req_ready, res_valid, res_last, res_data,
        input  grant, res_sel, busy, timeout
    );
endinterface

// File: rtl/rr_burst_arbiter.sv
// Round-robin arbiter that locks one requester onto the shared resource for a whole burst.
// The owner is released after its last beat, or after TIMEOUT consecutive idle cycles.
module rr_burst_arbiter #(
    parameter int unsigned N       = 4,
    parameter int unsigned DW      = 8,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst,
    rr_burst_arbiter_if.slave bus
);
    localparam int unsigned IW    = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned CW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit          TO_EN = (TIMEOUT > 0);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e        state_q, state_d;
    logic [IW-1:0] sel_q, sel_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grant_q, grant_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          timeout_q, timeout_d;

    logic [DW-1:0] lane_data [N];
    logic [IW-1:0] winner;
    logic          any_valid;
    logic          own_valid;
    logic          own_last;
    logic          last_fire;
    logic          idle_expire;
    logic [IW-1:0] next_ptr;

    for (genvar i = 0; i < N; i++) begin : g_lane
        assign lane_data[i] = bus.req_data[i*DW +: DW];
    end

    assign own_valid   = bus.req_valid[sel_q];
    assign own_last    = bus.req_last[sel_q];
    assign last_fire   = own_valid && bus.res_ready && own_last;
    assign idle_expire = TO_EN && !own_valid && ((32'(cnt_q) + 32'd1) == 32'(TIMEOUT));
    assign next_ptr    = (sel_q == IW'(N - 1)) ? '0 : sel_q + IW'(1);

    // First valid requester scanning upward from ptr, wrapping mod N.
    always_comb begin
        logic [IW-1:0] idx;
        winner    = '0;
        any_valid = 1'b0;
        idx       = '0;
        for (int unsigned k = 0; k < N; k++) begin
            idx = IW'((32'(ptr_q) + k) % N);
            if (!any_valid && bus.req_valid[idx]) begin
                any_valid = 1'b1;
                winner    = idx;
            end
        end
    end

    // Next-state: grant on any request, release on last beat or idle timeout.
    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        ptr_d     = ptr_q;
        grant_d   = grant_q;
        cnt_d     = cnt_q;
        timeout_d = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (any_valid) begin
                    state_d = BUSY;
                    sel_d   = winner;
                    grant_d = N'(1) << winner;
                end
            end
            BUSY: begin
                if (own_valid || !TO_EN) begin
                    cnt_d = '0;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (last_fire || idle_expire) begin
                    state_d   = IDLE;
                    sel_d     = '0;
                    grant_d   = '0;
                    ptr_d     = next_ptr;
                    cnt_d     = '0;
                    timeout_d = !last_fire;
                end
            end
            default: begin
                state_d = IDLE;
                sel_d   = '0;
                grant_d = '0;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            sel_q     <= '0;
            ptr_q     <= '0;
            grant_q   <= '0;
            cnt_q     <= '0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            ptr_q     <= ptr_d;
            grant_q   <= grant_d;
            cnt_q     <= cnt_d;
            timeout_q <= timeout_d;
        end
    end

    // Beat path: only the owner sees ready; everything reads 0 while idle.
    always_comb begin
        bus.req_ready = '0;
        bus.res_valid = 1'b0;
        bus.res_last  = 1'b0;
        bus.res_data  = '0;
        if (state_q == BUSY) begin
            bus.req_ready[sel_q] = bus.res_ready;
            bus.res_valid        = own_valid;
            bus.res_last         = own_last;
            bus.res_data         = lane_data[sel_q];
        end
    end

    assign bus.grant   = grant_q;
    assign bus.res_sel = sel_q;
    assign bus.busy    = (state_q == BUSY);
    assign bus.timeout = timeout_q;
endmodule
